// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter: shares the single access port of the write-back cache
// among NREQ requesters. Round-robin grant, one transaction in flight at a
// time, response routed back to the granted requester only. A watchdog
// converts a cache that never completes into an error response.
module cache_port_arbiter #(
    parameter int NREQ    = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    // requester side
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ-1:0]          req_write,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_hit,
    output logic                     rsp_err,
    // cache side
    output logic                     c_valid,
    input  logic                     c_ready,
    output logic [ADDR_W-1:0]        c_addr,
    output logic                     c_write,
    output logic [DATA_W-1:0]        c_wdata,
    input  logic                     c_rsp_valid,
    input  logic [DATA_W-1:0]        c_rdata,
    input  logic                     c_hit
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   ptr;        // requester with highest priority next time
    logic [PTR_W-1:0]   gnt;        // requester owning the in-flight transaction
    logic [TMR_W-1:0]   timer;      // WAIT cycles elapsed

    logic               grant_any;
    logic [PTR_W-1:0]   grant_idx;
    logic [NREQ-1:0]    grant;
    logic [NREQ-1:0]    gnt_onehot;

    // Round-robin pick: first valid requester scanning ptr, ptr+1, ... mod NREQ.
    always_comb begin
        int idx;
        // NOTE: every variable gets a default before the loop so no path
        // leaves it unassigned; otherwise synthesis would infer a latch.
        idx       = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                grant_idx = PTR_W'(idx);
            end
        end
    end

    assign grant      = grant_any ? (NREQ'(1) << grant_idx) : '0;
    assign gnt_onehot = NREQ'(1) << gnt;

    // Accept is offered only while idle and never while reset is held.
    assign req_ready = (state == IDLE && !reset) ? grant : '0;

    // Transaction sequencer: accept, issue to cache, wait with watchdog, respond.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt       <= '0;
            timer     <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_hit   <= 1'b0;
            rsp_err   <= 1'b0;
            c_valid   <= 1'b0;
            c_addr    <= '0;
            c_write   <= 1'b0;
            c_wdata   <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples the pre-edge values, independent of ordering.
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        c_addr  <= req_addr[grant_idx*ADDR_W +: ADDR_W];
                        c_write <= req_write[grant_idx];
                        c_wdata <= req_wdata[grant_idx*DATA_W +: DATA_W];
                        gnt     <= grant_idx;
                        c_valid <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    // No watchdog here: a busy cache may stall acceptance freely.
                    if (c_ready) begin
                        c_valid <= 1'b0;
                        timer   <= '0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    // timer + 1 never exceeds TIMEOUT, so it cannot wrap.
                    timer <= timer + 1'b1;
                    if (c_rsp_valid) begin
                        // A completion in the timeout cycle still counts as good.
                        rsp_rdata <= c_rdata;
                        rsp_hit   <= c_hit;
                        rsp_err   <= 1'b0;
                        rsp_valid <= gnt_onehot;
                        state     <= RESP;
                    end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                        rsp_rdata <= '0;
                        rsp_hit   <= 1'b0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= gnt_onehot;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    ptr   <= (gnt == PTR_W'(NREQ - 1)) ? '0 : gnt + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Self-checking bench for cache_port_arbiter. Inputs are driven on the falling
// edge, outputs sampled 1 time unit later. A transaction-level reference model
// predicts grants, the cache-side request window and the response cycle/data.
module tb_cache_port_arbiter;

    localparam int NREQ    = 2;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;

    logic                   clk;
    logic                   reset;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ-1:0]        req_write;
    logic [NREQ*DATA_W-1:0] req_wdata;
    logic [NREQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]      rsp_rdata;
    logic                   rsp_hit;
    logic                   rsp_err;
    logic                   c_valid;
    logic                   c_ready;
    logic [ADDR_W-1:0]      c_addr;
    logic                   c_write;
    logic [DATA_W-1:0]      c_wdata;
    logic                   c_rsp_valid;
    logic [DATA_W-1:0]      c_rdata;
    logic                   c_hit;

    cache_port_arbiter #(
        .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_hit(rsp_hit), .rsp_err(rsp_err),
        .c_valid(c_valid), .c_ready(c_ready), .c_addr(c_addr), .c_write(c_write),
        .c_wdata(c_wdata), .c_rsp_valid(c_rsp_valid), .c_rdata(c_rdata), .c_hit(c_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // ---------------- reference model state ----------------
    bit                 busy = 0;     // a transaction is accepted and not yet answered
    int                 g_cur, acc_cyc, hs_cyc, rsp_at, d_cur;
    logic [ADDR_W-1:0]  cur_addr;
    logic               cur_write;
    logic [DATA_W-1:0]  cur_wdata;
    int                 m_ptr = 0;
    logic [DATA_W-1:0]  e_rdata, h_rdata = '0;
    logic               e_hit, e_err, h_hit = 0, h_err = 0;
    int                 resp_count = 0;

    // ---------------- stimulus knobs ----------------
    bit                 fv_en = 1;
    logic [NREQ-1:0]    fv = '0;
    bit                 ff_en = 0;
    logic [ADDR_W-1:0]  fa [NREQ];
    logic               fw [NREQ];
    logic [DATA_W-1:0]  fd [NREQ];
    int                 cr_hold = 0;     // cycles c_ready stays low in the issue window; -1 random
    int                 d_fix = 1;       // response delay after handshake; 0 never; -1 random
    bit                 frd_en = 0;
    logic [DATA_W-1:0]  frd;
    logic               fhit;
    bit                 noise_en = 0;    // stray c_rsp_valid outside the wait window

    // ---------------- observations ----------------
    int                 obs_acc_cyc = 0, obs_lat = 0, obs_cv_len = 0;
    logic [NREQ-1:0]    obs_rsp = '0;
    int                 glog[$];

    task automatic step();
        bit              busy0, in_issue, in_win;
        logic [NREQ-1:0] exp_rr, exp_rv;
        int              k, gi;
        @(negedge clk);
        cyc++;
        busy0    = busy;
        in_issue = busy && hs_cyc < 0 && cyc > acc_cyc;
        in_win   = busy && hs_cyc >= 0 && cyc > hs_cyc && cyc < rsp_at;

        req_valid = fv_en ? fv : NREQ'($urandom);
        for (int r = 0; r < NREQ; r++) begin
            req_addr[r*ADDR_W +: ADDR_W]  = ff_en ? fa[r] : ADDR_W'($urandom);
            req_write[r]                  = ff_en ? fw[r] : 1'($urandom);
            req_wdata[r*DATA_W +: DATA_W] = ff_en ? fd[r] : DATA_W'($urandom);
        end
        if (in_issue)
            c_ready = (cr_hold < 0) ? 1'($urandom) : (cyc - acc_cyc - 1 >= cr_hold);
        else
            c_ready = 1'($urandom);
        if (in_win)
            c_rsp_valid = (d_cur > 0 && cyc == hs_cyc + d_cur);
        else
            c_rsp_valid = noise_en && ($urandom_range(0, 3) == 0);
        c_rdata = frd_en ? frd  : DATA_W'($urandom);
        c_hit   = frd_en ? fhit : 1'($urandom);
        #1;

        // expected grant: first valid requester from the model pointer
        exp_rr = '0;
        gi     = -1;
        if (!busy0) begin
            for (int i = 0; i < NREQ; i++) begin
                k = (m_ptr + i) % NREQ;
                if (gi < 0 && req_valid[k]) begin
                    gi = k;
                    exp_rr[k] = 1'b1;
                end
            end
        end
        check("req_ready", req_ready, exp_rr);

        check("c_valid", c_valid, in_issue);
        if (in_issue) begin
            check("c_addr", c_addr, cur_addr);
            check("c_write", c_write, cur_write);
            check("c_wdata", c_wdata, cur_wdata);
        end

        if (in_win && c_rsp_valid) begin
            e_rdata = c_rdata;
            e_hit   = c_hit;
            e_err   = 1'b0;
        end
        exp_rv = (busy0 && cyc == rsp_at) ? NREQ'(1 << g_cur) : '0;
        check("rsp_valid", rsp_valid, exp_rv);
        if (busy0 && cyc == rsp_at) begin
            h_rdata = e_rdata;
            h_hit   = e_hit;
            h_err   = e_err;
        end
        check("rsp_rdata", rsp_rdata, h_rdata);
        check("rsp_hit", rsp_hit, h_hit);
        check("rsp_err", rsp_err, h_err);

        // observations taken from the DUT for the directed end-of-test checks
        if (c_valid) obs_cv_len++;
        if (|(req_ready & req_valid)) begin
            obs_acc_cyc = cyc;
            obs_cv_len  = 0;
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) glog.push_back(i);
        end
        if (|rsp_valid) begin
            obs_lat = cyc - obs_acc_cyc;
            obs_rsp = rsp_valid;
        end

        // model advance
        if (in_issue && c_ready) begin
            hs_cyc  = cyc;
            e_rdata = '0;
            e_hit   = 1'b0;
            e_err   = 1'b1;
            rsp_at  = (d_cur >= 1 && d_cur <= TIMEOUT) ? cyc + d_cur + 1 : cyc + TIMEOUT + 1;
        end
        if (busy0 && cyc == rsp_at) begin
            m_ptr = (g_cur + 1) % NREQ;
            busy  = 0;
            resp_count++;
        end
        if (gi >= 0) begin
            busy      = 1;
            g_cur     = gi;
            acc_cyc   = cyc;
            hs_cyc    = -1;
            rsp_at    = -1;
            cur_addr  = req_addr[gi*ADDR_W +: ADDR_W];
            cur_write = req_write[gi];
            cur_wdata = req_wdata[gi*DATA_W +: DATA_W];
            d_cur     = (d_fix >= 0) ? d_fix : $urandom_range(0, 12);
        end
    endtask

    task automatic run_resp(input int target, input int budget);
        int start;
        start = resp_count;
        for (int i = 0; i < budget && resp_count < start + target; i++) step();
        if (resp_count < start + target) check("resp_budget", resp_count - start, target);
    endtask

    task automatic drain();
        fv_en = 1;
        fv    = '0;
        for (int i = 0; i < 40 && busy; i++) step();
        if (busy) check("drain_budget", busy, 0);
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_req_ready"}, req_ready, '0);
        check({pfx, "_rsp_valid"}, rsp_valid, '0);
        check({pfx, "_rsp_rdata"}, rsp_rdata, '0);
        check({pfx, "_rsp_hit"}, rsp_hit, 0);
        check({pfx, "_rsp_err"}, rsp_err, 0);
        check({pfx, "_c_valid"}, c_valid, 0);
        check({pfx, "_c_addr"}, c_addr, '0);
        check({pfx, "_c_write"}, c_write, 0);
        check({pfx, "_c_wdata"}, c_wdata, '0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        req_valid   = '0;
        req_addr    = '0;
        req_write   = '0;
        req_wdata   = '0;
        c_ready     = 1'b0;
        c_rsp_valid = 1'b0;
        c_rdata     = '0;
        c_hit       = 1'b0;
        for (int r = 0; r < NREQ; r++) begin
            fa[r] = '0; fw[r] = 1'b0; fd[r] = '0;
        end
        #2;
        check_all_zero("por");
        @(negedge clk);
        reset = 1'b0;

        // lone read from requester 0, immediate cache
        fv = 2'b01; ff_en = 1; fa[0] = 32'h40; fw[0] = 1'b0; fd[0] = '0;
        cr_hold = 0; d_fix = 1; frd_en = 1; frd = 32'hDEADBEEF; fhit = 1'b1;
        run_resp(1, 20);
        check("t1_latency", obs_lat, 3);
        check("t1_rsp_valid", obs_rsp, 2'b01);
        check("t1_rdata", rsp_rdata, 32'hDEADBEEF);
        check("t1_hit", rsp_hit, 1);
        drain();

        // write from requester 1 with a cache stalling acceptance for 5 cycles
        fv = 2'b10; fa[1] = 32'h80; fw[1] = 1'b1; fd[1] = 32'h12345678;
        cr_hold = 5; d_fix = 2; frd_en = 0;
        run_resp(1, 30);
        check("t3_issue_cycles", obs_cv_len, 6);
        check("t3_rsp_valid", obs_rsp, 2'b10);
        drain();

        // both requesters busy: strict alternation starting at 0
        glog.delete();
        fv = 2'b11; ff_en = 0; cr_hold = -1; d_fix = -1; noise_en = 1;
        run_resp(6, 400);
        check("t2_grant_count", glog.size(), 6);
        for (int i = 0; i < glog.size(); i++) check("t2_grant_order", glog[i], i % 2);
        drain();

        // cache never answers: watchdog error, then a normal transaction
        noise_en = 0; fv = 2'b01; cr_hold = 0; d_fix = 0;
        run_resp(1, 40);
        check("t4_err", rsp_err, 1);
        check("t4_rdata", rsp_rdata, 0);
        check("t4_latency", obs_lat, TIMEOUT + 2);
        drain();
        fv = 2'b10; d_fix = 3;
        run_resp(1, 20);
        check("t4_next_err", rsp_err, 0);
        drain();

        // completion lands in the timeout cycle: response wins
        fv = 2'b01; d_fix = TIMEOUT; frd_en = 1; frd = 32'hA5A5A5A5; fhit = 1'b0;
        run_resp(1, 40);
        check("t5_err", rsp_err, 0);
        check("t5_rdata", rsp_rdata, 32'hA5A5A5A5);
        check("t5_latency", obs_lat, TIMEOUT + 2);
        drain();

        // reset in the middle of WAIT (pointer is 1 here)
        frd_en = 0; fv = 2'b11; d_fix = 0;
        for (int i = 0; i < 20 && !(busy && hs_cyc >= 0 && cyc > hs_cyc); i++) step();
        check("t6_in_wait", busy && hs_cyc >= 0, 1);
        #1;
        req_valid = 2'b11;
        reset     = 1'b1;
        #1;
        check_all_zero("t6_rst");
        req_valid   = '0;
        c_ready     = 1'b0;
        c_rsp_valid = 1'b0;
        #1;
        reset = 1'b0;
        busy = 0; m_ptr = 0; h_rdata = '0; h_hit = 0; h_err = 0;
        glog.delete();
        fv = 2'b11; d_fix = 1;
        run_resp(1, 20);
        check("t6_grants", glog.size(), 1);
        if (glog.size() > 0) check("t6_first_grant", glog[0], 0);
        drain();

        // randomized traffic
        fv_en = 0; ff_en = 0; cr_hold = -1; d_fix = -1; frd_en = 0; noise_en = 1;
        for (int i = 0; i < 3000; i++) step();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
